// File: rtl/wb_arbiter.sv
// Writeback arbiter: three 2-entry result FIFOs (ALU, MUL, LSQ) merged
// round-robin onto a single registered writeback port into the ROB.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rob_flush,

    input  logic        alu_wb_valid,
    output logic        alu_wb_ready,
    input  logic        alu_wb_error,
    input  logic [4:0]  alu_wb_ecause,
    input  logic [6:0]  alu_wb_robid,
    input  logic [31:0] alu_wb_result,

    input  logic        mul_wb_valid,
    output logic        mul_wb_ready,
    input  logic        mul_wb_error,
    input  logic [4:0]  mul_wb_ecause,
    input  logic [6:0]  mul_wb_robid,
    input  logic [31:0] mul_wb_result,

    input  logic        lsq_wb_valid,
    output logic        lsq_wb_ready,
    input  logic        lsq_wb_error,
    input  logic [4:0]  lsq_wb_ecause,
    input  logic [6:0]  lsq_wb_robid,
    input  logic [31:0] lsq_wb_result,

    output logic        wb_valid,
    output logic        wb_error,
    output logic [4:0]  wb_ecause,
    output logic [6:0]  wb_robid,
    output logic [31:0] wb_result
);

    // entry layout: {error, ecause[4:0], robid[6:0], result[31:0]}
    localparam int EW = 45;

    logic [2:0]    src_valid;
    logic [2:0]    src_ready;
    logic [2:0]    req;
    logic [EW-1:0] src_data [3];

    logic [EW-1:0] mem_q [3][2];
    logic [EW-1:0] mem_d [3][2];
    logic [2:0]    wr_ptr_q, wr_ptr_d;
    logic [2:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q [3];
    logic [1:0]    count_d [3];
    logic [1:0]    last_q, last_d;
    logic          wb_valid_q, wb_valid_d;
    logic [EW-1:0] wb_data_q, wb_data_d;

    logic [1:0]    order [3];
    logic          grant_any;
    logic [1:0]    grant_idx;
    logic [EW-1:0] grant_head;
    logic [2:0]    push;
    logic [2:0]    pop;

    assign src_valid   = {lsq_wb_valid, mul_wb_valid, alu_wb_valid};
    assign src_data[0] = {alu_wb_error, alu_wb_ecause, alu_wb_robid, alu_wb_result};
    assign src_data[1] = {mul_wb_error, mul_wb_ecause, mul_wb_robid, mul_wb_result};
    assign src_data[2] = {lsq_wb_error, lsq_wb_ecause, lsq_wb_robid, lsq_wb_result};

    // Ready depends only on occupancy, never on a same-cycle pop.
    always_comb begin
        src_ready = '0;
        req       = '0;
        for (int i = 0; i < 3; i++) begin
            src_ready[i] = ~rst & (count_q[i] != 2'(DEPTH));
            req[i]       = (count_q[i] != 2'd0);
        end
    end

    assign alu_wb_ready = src_ready[0];
    assign mul_wb_ready = src_ready[1];
    assign lsq_wb_ready = src_ready[2];

    // Round-robin: search last+1, last+2, last+3 (mod 3); first requester wins.
    always_comb begin
        case (last_q)
            2'd0:    order = '{2'd1, 2'd2, 2'd0};
            2'd1:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!grant_any && req[order[k]]) begin
                grant_any = 1'b1;
                grant_idx = order[k];
            end
        end
        grant_head = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_idx == 2'(i)) grant_head = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Next state for FIFOs, round-robin pointer and output register; flush wins over push/pop.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        wb_valid_d = grant_any & ~rob_flush;
        wb_data_d  = wb_data_q;
        push       = '0;
        pop        = '0;

        if (grant_any) begin
            wb_data_d = grant_head;
            if (!rob_flush) last_d = grant_idx;
        end

        for (int i = 0; i < 3; i++) begin
            push[i] = src_valid[i] & src_ready[i] & ~rob_flush;
            pop[i]  = grant_any & (grant_idx == 2'(i)) & ~rob_flush;
            if (rob_flush) begin
                wr_ptr_d[i] = 1'b0;
                rd_ptr_d[i] = 1'b0;
                count_d[i]  = 2'd0;
            end else begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = src_data[i];
                    wr_ptr_d[i]           = ~wr_ptr_q[i];
                end
                if (pop[i]) rd_ptr_d[i] = ~rd_ptr_q[i];
                case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + 2'd1;
                    2'b01:   count_d[i] = count_q[i] - 2'd1;
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // State registers; reset leaves ALU with first priority (last = 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
                count_q[i]  <= 2'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= 2'd2;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign {wb_error, wb_ecause, wb_robid, wb_result} = wb_data_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that collects completed results from the three execution sources (ALU, multiply/divide, load/store queue) and drives the single writeback port into the reorder buffer. Each source pushes results through its own 2-entry FIFO with a valid/ready handshake. A round-robin arbiter selects one FIFO head per cycle onto a registered `wb_*` bus. There is no backpressure from the ROB. A ROB flush discards all buffered results.

## Interface
- `DEPTH`, 2: entries per source FIFO; fixed at 2, occupancy counter 2 bits.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rob_flush` in 1: flush from ROB; discards buffered and incoming results.
- `alu_wb_valid` in 1: ALU result offered.
- `alu_wb_ready` out 1: ALU FIFO can accept.
- `alu_wb_error` in 1: ALU result raises exception.
- `alu_wb_ecause` in 5: ALU exception cause.
- `alu_wb_robid` in 7: ROB index of the ALU result.
- `alu_wb_result` in 32: ALU result value.
- `mul_wb_valid`, `mul_wb_ready`, `mul_wb_error`, `mul_wb_ecause`, `mul_wb_robid`, `mul_wb_result`: same directions, widths and meanings as the ALU set; this is source 1.
- `lsq_wb_valid`, `lsq_wb_ready`, `lsq_wb_error`, `lsq_wb_ecause`, `lsq_wb_robid`, `lsq_wb_result`: same as the ALU set; this is source 2.
- `wb_valid` out 1: writeback to ROB this cycle.
- `wb_error` out 1: exception flag to ROB.
- `wb_ecause` out 5: exception cause to ROB.
- `wb_robid` out 7: target ROB entry.
- `wb_result` out 32: result value.

## Operation
- Per-source FIFO:
  - 2 entries, each {error, ecause, robid, result}.
  - Write pointer, read pointer and 2-bit count.
  - Push when `x_wb_valid & x_wb_ready & ~rob_flush`.
  - `x_wb_ready = ~rst & (count != 2)`. It does not depend on `x_wb_valid` or on a same-cycle pop, so a full FIFO deasserts ready even when popping that cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers are 1 bit and wrap naturally.
- Arbitration:
  - Requesters are the sources with count != 0.
  - Round-robin pointer `last` (2 bits, values 0–2) holds the most recently granted source.
  - Search order is `last+1`, `last+2`, `last+3`, each taken mod 3.
  - The first requester in that order is granted and popped, and `last` updates to it.
  - With no requester, `last` holds.
- Output register:
  - Each cycle, `wb_valid <= grant_any & ~rob_flush`.
  - `wb_error`, `wb_ecause`, `wb_robid` and `wb_result` load from the granted head when `grant_any`; otherwise they hold their previous value.
  - Downstream qualifies these fields only by `wb_valid`.
- Flush, when `rob_flush` is high in cycle C:
  - At the C edge, all counts and pointers clear to 0 and no pop occurs.
  - Any push offered in C is dropped, even though ready may be high.
  - `wb_valid` is 0 in C+1.
  - `wb_valid` driven during C is still presented; the ROB ignores it.
  - `last` is unchanged by flush.
- Reset: counts and pointers go to 0, `last` = 2 (ALU has first priority), `wb_valid` = 0, and data outputs go to 0.

## Timing
- Reset values: `wb_valid`, `wb_error`, `wb_ecause`, `wb_robid`, `wb_result` all 0. All `x_wb_ready` are 0 while `rst` is high and 1 in the first cycle after.
- Latency: a push accepted in cycle N is stored at the N edge, can be granted in N+1, and appears with `wb_valid`=1 in N+2 at the earliest. There is no bypass.
- Throughput: one writeback per cycle in aggregate; a single source sustains one per cycle.
- Flush has priority over push and pop; reset has priority over flush.
- Ordering within a source is FIFO. Across sources, ordering is only round-robin; `robid` order is not guaranteed.

## Test plan
- Single push:
  - ALU push robid=5, result=0xDEADBEEF at cycle 1.
  - Expect `wb_valid`=1, robid=5, result=0xDEADBEEF in cycle 3 only.
- Three-way tie from reset:
  - All three sources push in cycle 1 with robids 1, 2, 3.
  - Expect writebacks robid 1, 2, 3 in cycles 3, 4, 5.
- Fill and backpressure:
  - MUL pushes every cycle while ALU and LSQ each hold two entries.
  - Expect `mul_wb_ready`=0 while MUL count is 2.
  - Expect no MUL entry lost or duplicated, and MUL robids emerging in push order.
- Round-robin fairness:
  - Keep ALU and LSQ continuously non-empty, MUL idle.
  - Expect grants to alternate ALU, LSQ, ALU, LSQ.
- Flush mid-stream:
  - With 5 results buffered, assert `rob_flush` in cycle C with a new ALU push in C.
  - Expect `wb_valid`=0 from C+1 on, all readies = 1 in C+1, and the dropped push never written back.
- Reset mid-operation:
  - Assert `rst` with FIFOs non-empty.
  - Expect all outputs 0 and readies 0 during reset.
  - Afterwards, the first tie is granted ALU first and no stale result appears.
